// File: rtl/aead_frame_splitter_if.sv
// Stream bundle for aead_frame_splitter: one received frame stream in, AAD and
// ciphertext streams out. The splitter uses the slave modport; the environment
// feeding frames and sinking the split streams uses the master modport.
interface aead_frame_splitter_if;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;

  logic [31:0] aad_data;
  logic [3:0]  aad_keep;
  logic        aad_valid;
  logic        aad_last;
  logic        aad_ready;

  logic [31:0] ct_data;
  logic [3:0]  ct_keep;
  logic        ct_valid;
  logic        ct_last;
  logic        ct_ready;

  modport master (
    output in_data, in_valid,
    input  in_ready,
    input  aad_data, aad_keep, aad_valid, aad_last,
    output aad_ready,
    input  ct_data, ct_keep, ct_valid, ct_last,
    output ct_ready
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready,
    output aad_data, aad_keep, aad_valid, aad_last,
    input  aad_ready,
    output ct_data, ct_keep, ct_valid, ct_last,
    input  ct_ready
  );
endinterface

// File: rtl/aead_frame_splitter.sv
// Splits a received AEAD frame (AAD words, CT words, 4 tag words) into separate
// AAD and ciphertext streams and captures the 128-bit Poly1305 tag.
// Optional macro SPLITTER_TAG_CMP_EN builds a registered received-vs-expected
// tag comparator; without it tag_match is tied low and expected_tag is unused.
module aead_frame_splitter (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        chip_enable,
  input  logic                        start,
  input  logic [15:0]                 aad_len,
  input  logic [15:0]                 ct_len,
  aead_frame_splitter_if.slave        bus,
  output logic [127:0]                tag,
  output logic                        tag_valid,
  input  logic [127:0]                expected_tag,
  output logic                        tag_match,
  output logic                        busy,
  output logic                        done
);

  typedef enum logic [1:0] {StIdle, StAad, StCt, StTag} state_e;

  state_e       state_q, state_d;
  logic [15:0]  aad_len_q, aad_len_d;
  logic [15:0]  ct_len_q, ct_len_d;
  logic [15:0]  cnt_q, cnt_d;
  logic [127:0] tag_q, tag_d;
  logic         tag_valid_q, tag_valid_d;
  logic         done_q, done_d;
  logic [16:0]  aad_words, ct_words;
  logic         aad_is_last, ct_is_last;
  logic         start_acc, tag_last;

  // Keep mask for a field's final word; a multiple of 4 fills the word.
  function automatic logic [3:0] last_keep(input logic [1:0] rem);
    logic [3:0] k;
    unique case (rem)
      2'd0: k = 4'b1111;
      2'd1: k = 4'b0001;
      2'd2: k = 4'b0011;
      default: k = 4'b0111;
    endcase
    return k;
  endfunction

  assign aad_words   = ({1'b0, aad_len_q} + 17'd3) >> 2;
  assign ct_words    = ({1'b0, ct_len_q} + 17'd3) >> 2;
  assign aad_is_last = ({1'b0, cnt_q} == aad_words - 17'd1);
  assign ct_is_last  = ({1'b0, cnt_q} == ct_words - 17'd1);

  assign tag       = tag_q;
  assign tag_valid = tag_valid_q;
  assign done      = done_q;
  assign busy      = (state_q != StIdle);

  // State, latched lengths, word counter, tag and end-of-frame pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      aad_len_q   <= '0;
      ct_len_q    <= '0;
      cnt_q       <= '0;
      tag_q       <= '0;
      tag_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      aad_len_q   <= aad_len_d;
      ct_len_q    <= ct_len_d;
      cnt_q       <= cnt_d;
      tag_q       <= tag_d;
      tag_valid_q <= tag_valid_d;
      done_q      <= done_d;
    end
  end

  // Next state and zero-latency stream routing; a channel is driven only in its own state.
  always_comb begin
    state_d       = state_q;
    aad_len_d     = aad_len_q;
    ct_len_d      = ct_len_q;
    cnt_d         = cnt_q;
    tag_d         = tag_q;
    tag_valid_d   = 1'b0;
    done_d        = 1'b0;
    start_acc     = 1'b0;
    tag_last      = 1'b0;
    bus.in_ready  = 1'b0;
    bus.aad_data  = '0;
    bus.aad_keep  = '0;
    bus.aad_valid = 1'b0;
    bus.aad_last  = 1'b0;
    bus.ct_data   = '0;
    bus.ct_keep   = '0;
    bus.ct_valid  = 1'b0;
    bus.ct_last   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (chip_enable && start) begin
          start_acc = 1'b1;
          aad_len_d = aad_len;
          ct_len_d  = ct_len;
          cnt_d     = '0;
          tag_d     = '0;
          if (aad_len != 16'd0)     state_d = StAad;
          else if (ct_len != 16'd0) state_d = StCt;
          else                      state_d = StTag;
        end
      end
      StAad: begin
        bus.aad_data  = bus.in_data;
        bus.aad_valid = chip_enable & bus.in_valid;
        bus.aad_last  = aad_is_last;
        bus.aad_keep  = aad_is_last ? last_keep(aad_len_q[1:0]) : 4'b1111;
        bus.in_ready  = chip_enable & bus.aad_ready;
        if (chip_enable && bus.in_valid && bus.aad_ready) begin
          if (aad_is_last) begin
            cnt_d   = '0;
            state_d = (ct_len_q != 16'd0) ? StCt : StTag;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      StCt: begin
        bus.ct_data  = bus.in_data;
        bus.ct_valid = chip_enable & bus.in_valid;
        bus.ct_last  = ct_is_last;
        bus.ct_keep  = ct_is_last ? last_keep(ct_len_q[1:0]) : 4'b1111;
        bus.in_ready = chip_enable & bus.ct_ready;
        if (chip_enable && bus.in_valid && bus.ct_ready) begin
          if (ct_is_last) begin
            cnt_d   = '0;
            state_d = StTag;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      StTag: begin
        bus.in_ready = chip_enable;
        if (chip_enable && bus.in_valid) begin
          unique case (cnt_q[1:0])
            2'd0: tag_d[31:0]   = bus.in_data;
            2'd1: tag_d[63:32]  = bus.in_data;
            2'd2: tag_d[95:64]  = bus.in_data;
            default: tag_d[127:96] = bus.in_data;
          endcase
          if (cnt_q[1:0] == 2'd3) begin
            tag_last    = 1'b1;
            tag_valid_d = 1'b1;
            done_d      = 1'b1;
            cnt_d       = '0;
            state_d     = StIdle;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

`ifdef SPLITTER_TAG_CMP_EN
  logic tag_match_q, tag_match_d;

  // Compare the fully assembled tag as the last word lands; hold until next start.
  always_comb begin
    tag_match_d = tag_match_q;
    if (start_acc) begin
      tag_match_d = 1'b0;
    end else if (tag_last) begin
      tag_match_d = ({bus.in_data, tag_q[95:0]} == expected_tag);
    end
  end

  // Registered compare result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) tag_match_q <= 1'b0;
    else     tag_match_q <= tag_match_d;
  end

  assign tag_match = tag_match_q;
`else
  logic unused_cmp;
  assign unused_cmp = ^{expected_tag, start_acc, tag_last};
  assign tag_match  = 1'b0;
`endif

endmodule

// File: tb/tb_aead_frame_splitter.sv
// Directed bench for aead_frame_splitter: table of frame shapes plus hand-written
// sequences for backpressure/freeze, mid-frame reset, start-while-busy and tag compare.
module tb_aead_frame_splitter;

  localparam logic [127:0] Tag = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
`ifdef SPLITTER_TAG_CMP_EN
  localparam logic CmpEn = 1'b1;
`else
  localparam logic CmpEn = 1'b0;
`endif

  logic         clk, rst, chip_enable, start, tag_valid, tag_match, busy, done;
  logic [15:0]  aad_len, ct_len;
  logic [127:0] tag, expected_tag;
  logic         toggle_en;
  int           checks, failures;

  aead_frame_splitter_if bus ();

  aead_frame_splitter dut (
    .clk          (clk),
    .rst          (rst),
    .chip_enable  (chip_enable),
    .start        (start),
    .aad_len      (aad_len),
    .ct_len       (ct_len),
    .bus          (bus.slave),
    .tag          (tag),
    .tag_valid    (tag_valid),
    .expected_tag (expected_tag),
    .tag_match    (tag_match),
    .busy         (busy),
    .done         (done)
  );

  typedef struct {
    logic [15:0] al;
    logic [15:0] cl;
    int          aw;
    logic [3:0]  ak;
    int          cw;
    logic [3:0]  ck;
  } vec_t;

  vec_t tbl [6];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ct_ready is 1 unless toggling is enabled.
  initial begin
    bus.ct_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.ct_ready = toggle_en ? ~bus.ct_ready : 1'b1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running want finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [135:0] act, input logic [135:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic start_frame(input logic [15:0] al, input logic [15:0] cl);
    aad_len = al;
    ct_len  = cl;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start   = 1'b0;
    aad_len = 16'hFFFF;
    ct_len  = 16'hFFFF;
  endtask

  // ch: 0 = AAD, 1 = CT, 2 = tag word.
  task automatic beat(input int ch, input logic [31:0] d, input logic [3:0] keep,
                      input logic last, input string name);
    bit got = 0;
    bus.in_data  = d;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        got = 1;
        if (ch == 0)
          chk(name, {bus.aad_valid, bus.aad_keep, bus.aad_last, bus.aad_data, bus.ct_valid, busy},
              {1'b1, keep, last, d, 1'b0, 1'b1});
        else if (ch == 1)
          chk(name, {bus.ct_valid, bus.ct_keep, bus.ct_last, bus.ct_data, bus.aad_valid, busy},
              {1'b1, keep, last, d, 1'b0, 1'b1});
        else
          chk(name, {bus.aad_valid, bus.ct_valid, busy, tag_valid, done},
              {1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
      end
      @(posedge clk);
      #1;
    end
    if (!got) chk({name, " timeout"}, 136'd0, 136'd1);
    bus.in_valid = 1'b0;
  endtask

  task automatic tag_beats();
    for (int i = 0; i < 4; i++) begin
      logic [7:0] b;
      b = 8'(4 * i);
      beat(2, {b + 8'd3, b + 8'd2, b + 8'd1, b}, 4'b0000, 1'b0, "tag word");
    end
  endtask

  task automatic finish_frame(input logic exp_match);
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("end pulse", {tag_valid, done, busy, tag_match, tag}, {1'b1, 1'b1, 1'b0, exp_match, Tag});
    @(negedge clk);
    chk("end hold", {tag_valid, done, busy, tag_match, tag}, {1'b0, 1'b0, 1'b0, exp_match, Tag});
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input vec_t v, input logic exp_match);
    start_frame(v.al, v.cl);
    for (int w = 0; w < v.aw; w++)
      beat(0, 32'hAD00_0000 + 32'(w), (w == v.aw - 1) ? v.ak : 4'b1111, w == v.aw - 1, "aad word");
    for (int w = 0; w < v.cw; w++)
      beat(1, 32'hC700_0000 + 32'(w), (w == v.cw - 1) ? v.ck : 4'b1111, w == v.cw - 1, "ct word");
    tag_beats();
    finish_frame(exp_match);
  endtask

  initial begin
    vec_t v;
    checks       = 0;
    failures     = 0;
    toggle_en    = 1'b0;
    rst          = 1'b1;
    chip_enable  = 1'b1;
    start        = 1'b0;
    aad_len      = 16'd0;
    ct_len       = 16'd0;
    expected_tag = Tag;
    bus.in_data  = 32'hFFFF_FFFF;
    bus.in_valid = 1'b1;
    bus.aad_ready = 1'b1;

    tbl[0] = '{al: 16'd5, cl: 16'd8, aw: 2, ak: 4'b0001, cw: 2, ck: 4'b1111};
    tbl[1] = '{al: 16'd0, cl: 16'd3, aw: 0, ak: 4'b0000, cw: 1, ck: 4'b0111};
    tbl[2] = '{al: 16'd0, cl: 16'd0, aw: 0, ak: 4'b0000, cw: 0, ck: 4'b0000};
    tbl[3] = '{al: 16'd4, cl: 16'd4, aw: 1, ak: 4'b1111, cw: 1, ck: 4'b1111};
    tbl[4] = '{al: 16'd6, cl: 16'd7, aw: 2, ak: 4'b0011, cw: 2, ck: 4'b0111};
    tbl[5] = '{al: 16'd1, cl: 16'd0, aw: 1, ak: 4'b0001, cw: 0, ck: 4'b0000};

    @(negedge clk);
    @(negedge clk);
    chk("reset state",
        {busy, done, tag_valid, tag_match, bus.in_ready, bus.aad_valid, bus.ct_valid,
         bus.aad_keep, bus.ct_keep, tag},
        136'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.in_valid = 1'b0;

    for (int i = 0; i < 6; i++) run_frame(tbl[i], CmpEn);

    // Start while busy: new lengths must not be taken.
    start_frame(16'd4, 16'd4);
    start   = 1'b1;
    aad_len = 16'd0;
    ct_len  = 16'd0;
    beat(0, 32'h1111_2222, 4'b1111, 1'b1, "busy start aad");
    start = 1'b0;
    beat(1, 32'h3333_4444, 4'b1111, 1'b1, "busy start ct");
    tag_beats();
    finish_frame(CmpEn);

    // ct_ready toggling and a 3-cycle freeze mid-CT.
    toggle_en = 1'b1;
    start_frame(16'd0, 16'd16);
    beat(1, 32'hC700_0000, 4'b1111, 1'b0, "toggle ct0");
    beat(1, 32'hC700_0001, 4'b1111, 1'b0, "toggle ct1");
    chip_enable  = 1'b0;
    bus.in_data  = 32'hC700_0002;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("freeze", {bus.in_ready, bus.ct_valid, bus.aad_valid, busy}, {3'b000, 1'b1});
      @(posedge clk);
      #1;
    end
    chip_enable = 1'b1;
    beat(1, 32'hC700_0002, 4'b1111, 1'b0, "toggle ct2");
    beat(1, 32'hC700_0003, 4'b1111, 1'b1, "toggle ct3");
    toggle_en = 1'b0;
    tag_beats();
    finish_frame(CmpEn);

    // Reset mid-CT forces outputs low immediately, then a clean frame.
    start_frame(16'd0, 16'd8);
    beat(1, 32'hC700_0000, 4'b1111, 1'b0, "pre-reset ct0");
    bus.in_data  = 32'hC700_0001;
    bus.in_valid = 1'b1;
    rst = 1'b1;
    #1;
    chk("mid reset",
        {busy, done, tag_valid, tag_match, bus.in_ready, bus.aad_valid, bus.ct_valid,
         bus.ct_last, bus.aad_keep, bus.ct_keep},
        136'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.in_valid = 1'b0;
    v = '{al: 16'd4, cl: 16'd4, aw: 1, ak: 4'b1111, cw: 1, ck: 4'b1111};
    run_frame(v, CmpEn);

    // Mismatching expected tag (bit 127 flipped).
    expected_tag = Tag ^ {1'b1, 127'd0};
    run_frame(tbl[2], 1'b0);
    expected_tag = Tag;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
